imem_load_ctrl: RTL and testbench

Sequencer and port arbiter for the single-port, word-addressed instruction memory of the single-cycle MIPS core. It owns the memory's address, write-data and write-enable lines. In normal operation it passes CPU fetches straight through. On request, it holds the CPU, accepts a program as a byte stream over a valid/ready handshake, packs the bytes into 32-bit words and writes them to consecutive word addresses starting at 0. It then releases the CPU.

---
 rtl/imem_pkg.sv | 23 ++
 rtl/imem_load_ctrl_if.sv | 36 +++
 rtl/imem_byte_packer.sv | 54 +++++
 rtl/imem_load_ctrl.sv | 134 +++++++++++++
 tb/tb_imem_load_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load controller.
package imem_pkg;

  // Controller states; encoding is fixed so it can be probed by number.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Instruction returned to the CPU while it is held (MIPS sll $0,$0,0).
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Program bytes packed into one instruction word.
  localparam int BYTES_PER_WORD = 4;

  // A load length is usable when it names at least one word and fits in memory.
  function automatic logic len_legal(input logic [31:0] len, input logic [31:0] depth);
    return (len != 32'd0) && (len <= depth);
  endfunction

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Bundle of the load-request, byte-stream, fetch and memory signals.
// slave: the controller side. master: the CPU / loader / memory side.
interface imem_load_ctrl_if #(
  parameter int WL_addr = 32,
  parameter int WL_data = 32,
  parameter int LEN_W   = 8
);

  logic               load_start;
  logic [LEN_W-1:0]   load_len;
  logic [7:0]         byte_data;
  logic               byte_valid;
  logic               byte_ready;
  logic [WL_addr-1:0] fetch_addr;
  logic [WL_data-1:0] fetch_data;
  logic [WL_addr-1:0] mem_addr;
  logic [WL_data-1:0] mem_wdata;
  logic               mem_we;
  logic [WL_data-1:0] mem_rdata;
  logic               cpu_hold;
  logic               load_done;
  logic               load_err;

  modport slave (
    input  load_start, load_len, byte_data, byte_valid, fetch_addr, mem_rdata,
    output byte_ready, fetch_data, mem_addr, mem_wdata, mem_we, cpu_hold,
           load_done, load_err
  );

  modport master (
    output load_start, load_len, byte_data, byte_valid, fetch_addr, mem_rdata,
    input  byte_ready, fetch_data, mem_addr, mem_wdata, mem_we, cpu_hold,
           load_done, load_err
  );

endinterface

// File: rtl/imem_byte_packer.sv
// Collects four program bytes into one big-endian instruction word.
// The first byte accepted lands in bits [31:24]; the word stays stable
// after the fourth byte so it can be written on the following cycle.
module imem_byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0] r_byte_cnt;

  // Byte position counter; wraps to 0 naturally after the fourth byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= 2'd0;
    end else if (i_clr) begin
      r_byte_cnt <= 2'd0;
    end else if (i_accept) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
    end
  end

  assign o_word_full = i_accept && (r_byte_cnt == LAST_IDX);

  // One register per byte lane, loaded when the counter points at it.
  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [7:0] r_lane;

      // Capture the accepted byte into this lane.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_lane <= 8'd0;
        end else if (i_clr) begin
          r_lane <= 8'd0;
        end else if (i_accept && (r_byte_cnt == LANE)) begin
          r_lane <= i_byte;
        end
      end

      assign o_word[31-8*gi -: 8] = r_lane;
    end
  endgenerate

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory port arbiter and program loader. Passes CPU fetches
// through while idle; on request holds the CPU, packs a byte stream into
// words and writes them to word addresses 0..len-1, then releases the CPU.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int WL_addr = 32,
  parameter int WL_data = 32,
  parameter int DEPTH   = 32,
  parameter int LEN_W   = 8
)
(
  input  logic             clk,
  input  logic             rst_n,
  imem_load_ctrl_if.slave  bus
);

  // One extra bit so the pointer can represent DEPTH itself.
  localparam int PTR_W = $clog2(DEPTH) + 1;

  state_t           r_state;
  state_t           w_state_next;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] w_ptr_inc;
  logic [LEN_W-1:0] r_len;
  logic             r_load_err;

  logic             w_len_ok;
  logic             w_start_ok;
  logic             w_start_bad;
  logic             w_accept;
  logic             w_word_full;
  logic             w_last_word;
  logic [31:0]      w_word;

  assign w_len_ok    = len_legal(32'(bus.load_len), 32'(DEPTH));
  assign w_start_ok  = (r_state == ST_IDLE) && bus.load_start && w_len_ok;
  assign w_start_bad = (r_state == ST_IDLE) && bus.load_start && !w_len_ok;
  assign w_accept    = bus.byte_valid && (r_state == ST_RECV);
  assign w_ptr_inc   = r_wr_ptr + 1'b1;
  assign w_last_word = (32'(w_ptr_inc) == 32'(r_len));

  imem_byte_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_start_ok),
    .i_accept    (w_accept),
    .i_byte      (bus.byte_data),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latch the load length and advance the write pointer after each write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_len    <= '0;
    end else if (w_start_ok) begin
      r_wr_ptr <= '0;
      r_len    <= bus.load_len;
    end else if (r_state == ST_WRITE) begin
      r_wr_ptr <= w_ptr_inc;
    end
  end

  // Sticky error flag: reflects the most recent request honoured in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_err <= 1'b0;
    end else if (w_start_ok) begin
      r_load_err <= 1'b0;
    end else if (w_start_bad) begin
      r_load_err <= 1'b1;
    end
  end

  assign bus.load_err = r_load_err;

  // Next-state logic and state-decoded port mux.
  always_comb begin
    w_state_next   = r_state;
    bus.mem_addr   = bus.fetch_addr;
    bus.fetch_data = bus.mem_rdata;
    bus.mem_wdata  = WL_data'(w_word);
    bus.mem_we     = 1'b0;
    bus.byte_ready = 1'b0;
    bus.cpu_hold   = 1'b0;
    bus.load_done  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_state_next = ST_RECV;
        end
      end
      ST_RECV: begin
        bus.byte_ready = 1'b1;
        bus.cpu_hold   = 1'b1;
        bus.fetch_data = WL_data'(NOP);
        bus.mem_addr   = WL_addr'(r_wr_ptr);
        if (w_word_full) begin
          w_state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        bus.mem_we     = 1'b1;
        bus.cpu_hold   = 1'b1;
        bus.fetch_data = WL_data'(NOP);
        bus.mem_addr   = WL_addr'(r_wr_ptr);
        w_state_next   = w_last_word ? ST_DONE : ST_RECV;
      end
      ST_DONE: begin
        bus.load_done  = 1'b1;
        bus.cpu_hold   = 1'b1;
        bus.fetch_data = WL_data'(NOP);
        bus.mem_addr   = WL_addr'(r_wr_ptr);
        w_state_next   = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Scoreboard bench for imem_load_ctrl: stimulus pushes expected memory
// writes into a queue, a negedge monitor pops and compares them.
module tb_imem_load_ctrl;
  import imem_pkg::*;

  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_load_ctrl_if #(.WL_addr(32), .WL_data(32), .LEN_W(8)) bus ();

  imem_load_ctrl #(.WL_addr(32), .WL_data(32), .DEPTH(DEPTH), .LEN_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem_model [DEPTH];
  bit          mem_init = 1'b0;
  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: preset contents once, then commit DUT writes.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem_model[i] <= 32'hDEAD_0000 + 32'(i);
      mem_model[5] <= 32'h2008_0005;
      mem_init <= 1'b1;
    end else if (bus.mem_we) begin
      mem_model[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = mem_model[bus.mem_addr[4:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard queue.
  always @(negedge clk) begin : monitor
    wr_t w;
    if (rst_n && bus.mem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        w = exp_q.pop_front();
        $display("write addr=%0d data=%h (expect addr=%0d data=%h)",
                 bus.mem_addr, bus.mem_wdata, w.addr, w.data);
        chk("write_addr", bus.mem_addr, w.addr);
        chk("write_data", bus.mem_wdata, w.data);
      end
    end
    if (rst_n && bus.cpu_hold) chk("nop_during_hold", bus.fetch_data, NOP);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic start_load(input logic [7:0] len);
    bus.load_start = 1'b1;
    bus.load_len   = len;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc;
    acc = 1'b0;
    if (gap) begin
      bus.byte_valid = 1'b0;
      tick();
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = bus.byte_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_checks++;
      n_err++;
      $display("FAIL byte_accept_timeout: got no byte_ready, expected acceptance of %h", b);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gap);
  endtask

  task automatic wait_done(output int at_cyc);
    bit seen;
    seen = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.load_done) begin
        seen = 1'b1;
        at_cyc = cyc;
      end
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL load_done_timeout: got no load_done, expected one within 40 cycles");
    end
  endtask

  int start_cyc;
  int done_cyc;

  initial begin
    bus.load_start = 1'b0;
    bus.load_len   = 8'd0;
    bus.byte_data  = 8'd0;
    bus.byte_valid = 1'b0;
    bus.fetch_addr = 32'd5;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_hold", 32'(bus.cpu_hold), 0);
    chk("rst_byte_ready", 32'(bus.byte_ready), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_load_done", 32'(bus.load_done), 0);
    chk("rst_load_err", 32'(bus.load_err), 0);
    chk("rst_mem_addr", bus.mem_addr, 32'd5);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Pass-through
    chk("pt_mem_addr", bus.mem_addr, 32'd5);
    chk("pt_fetch_data", bus.fetch_data, 32'h2008_0005);
    chk("pt_mem_we", 32'(bus.mem_we), 0);
    chk("pt_cpu_hold", 32'(bus.cpu_hold), 0);
    bus.fetch_addr = 32'd6;
    #1;
    chk("pt_fetch_data6", bus.fetch_data, 32'hDEAD_0006);

    // Single-word load, back-to-back bytes
    push_exp(32'd0, 32'h2008_0007);
    start_load(8'd1);
    start_cyc = cyc;
    chk("hold_after_start", 32'(bus.cpu_hold), 1);
    chk("ready_in_recv", 32'(bus.byte_ready), 1);
    send_word(32'h2008_0007, 1'b0);
    wait_done(done_cyc);
    chk("done_latency", 32'(done_cyc - start_cyc), 32'd5);
    @(negedge clk);
    chk("hold_released", 32'(bus.cpu_hold), 0);
    chk("done_one_cycle", 32'(bus.load_done), 0);
    bus.fetch_addr = 32'd0;
    #1;
    chk("readback_w0", bus.fetch_data, 32'h2008_0007);
    $display("single-word load done at cycle offset %0d", done_cyc - start_cyc);

    // Three-word load with byte_valid toggling
    push_exp(32'd0, 32'h2008_0001);
    push_exp(32'd1, 32'h2009_0002);
    push_exp(32'd2, 32'hAC09_0004);
    tick();
    start_load(8'd3);
    send_word(32'h2008_0001, 1'b1);
    send_word(32'h2009_0002, 1'b1);
    send_word(32'hAC09_0004, 1'b1);
    wait_done(done_cyc);
    @(negedge clk);
    bus.fetch_addr = 32'd2;
    #1;
    chk("readback_w2", bus.fetch_data, 32'hAC09_0004);
    chk("three_cpu_hold", 32'(bus.cpu_hold), 0);

    // Illegal lengths
    tick();
    start_load(8'd0);
    chk("err_len0", 32'(bus.load_err), 1);
    chk("err_len0_idle", 32'(bus.cpu_hold), 0);
    tick();
    chk("err_len0_stays_idle", 32'(bus.byte_ready), 0);
    start_load(8'(DEPTH + 1));
    chk("err_len33", 32'(bus.load_err), 1);
    chk("err_len33_idle", 32'(bus.cpu_hold), 0);
    push_exp(32'd0, 32'h1122_3344);
    start_load(8'd1);
    chk("err_cleared", 32'(bus.load_err), 0);
    send_word(32'h1122_3344, 1'b0);
    wait_done(done_cyc);
    @(negedge clk);

    // load_start pulsed during RECV is ignored
    push_exp(32'd0, 32'hA1A2_A3A4);
    push_exp(32'd1, 32'hB1B2_B3B4);
    tick();
    start_load(8'd2);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    bus.load_start = 1'b1;
    bus.load_len   = 8'd5;
    tick();
    bus.load_len   = 8'd0;
    tick();
    bus.load_start = 1'b0;
    chk("recv_start_no_err", 32'(bus.load_err), 0);
    send_byte(8'hA3, 1'b0);
    send_byte(8'hA4, 1'b0);
    send_word(32'hB1B2_B3B4, 1'b0);
    wait_done(done_cyc);
    @(negedge clk);

    // Reset after 2 bytes of word 1 in a 2-word load
    push_exp(32'd0, 32'hC0C1_C2C3);
    tick();
    start_load(8'd2);
    send_word(32'hC0C1_C2C3, 1'b0);
    send_byte(8'hD0, 1'b0);
    send_byte(8'hD1, 1'b0);
    bus.fetch_addr = 32'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cpu_hold", 32'(bus.cpu_hold), 0);
    chk("arst_byte_ready", 32'(bus.byte_ready), 0);
    chk("arst_mem_we", 32'(bus.mem_we), 0);
    chk("arst_mem_addr", bus.mem_addr, 32'd0);
    chk("arst_word0_kept", bus.fetch_data, 32'hC0C1_C2C3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push_exp(32'd0, 32'hE0E1_E2E3);
    start_load(8'd1);
    send_word(32'hE0E1_E2E3, 1'b0);
    wait_done(done_cyc);
    @(negedge clk);
    #1;
    chk("reload_word0", bus.fetch_data, 32'hE0E1_E2E3);
    bus.fetch_addr = 32'd1;
    #1;
    chk("word1_untouched", bus.fetch_data, 32'hB1B2_B3B4);

    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
